// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver states, default bit period and counter sizing helper
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
    localparam int CLKS_PER_BIT_DEF = 16;
    function automatic int cnt_w(input int p);
        return $clog2(p);
    endfunction
endpackage

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: received-word write port toward the fifo plus frame status
interface uart_rx_framer_if #(parameter int M = 8);
    logic         wr;
    logic [M-1:0] din;
    logic         frame_err;
    logic         busy;
    modport master(output wr, din, frame_err, busy);
    modport slave(input wr, din, frame_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one async input, resets to the idle-high level
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {q, m} <= 2'b11;
        else      {q, m} <= {m, d};
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling UART receiver emitting one fifo write per good frame
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int M            = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    uart_rx_framer_if.master  bus
);
    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int IW = $clog2(M + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(M - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic [M-1:0]  sh, sh_n, din, din_n;
    logic          wr, wr_n, err, err_n, busy, busy_n, rx_s;

    sync_2ff u_sync (.clk(clk), .rst(rst), .d(rx_in), .q(rx_s));

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            din   <= '0;
            wr    <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            din   <= din_n;
            wr    <= wr_n;
            err   <= err_n;
            busy  <= busy_n;
        end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        din_n   = din;
        wr_n    = 1'b0;
        err_n   = 1'b0;
        busy_n  = busy;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                    busy_n  = 1'b1;
                end
            end
            START: if (cnt == HALF_END) begin
                cnt_n   = '0;
                idx_n   = '0;
                state_n = rx_s ? IDLE : DATA;
                busy_n  = !rx_s;
            end
            // LSB arrives first, so right shifts leave it at bit 0 after M samples
            DATA: if (cnt == BIT_END) begin
                cnt_n   = '0;
                sh_n    = {rx_s, sh[M-1:1]};
                idx_n   = idx + 1'b1;
                state_n = (idx == LAST_BIT) ? STOP : DATA;
            end
            STOP: if (cnt == BIT_END) begin
                cnt_n   = '0;
                din_n   = rx_s ? sh : din;
                wr_n    = rx_s;
                err_n   = !rx_s;
                busy_n  = !rx_s;
                state_n = rx_s ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.wr        = wr;
    assign bus.din       = din;
    assign bus.frame_err = err;
    assign bus.busy      = busy;
endmodule
